// File: rtl/reg_writeback_pkg.sv
// Shared writeback types: register data/index types, grant source, starvation limit.
package opcodes;

    typedef logic [31:0] register_t;
    typedef logic [4:0]  register_num_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MEM
    } wb_src_t;

    localparam int STARVE_W = 3;
    localparam logic [STARVE_W-1:0] STARVE_LIMIT = 3'd4;

endpackage

// File: rtl/reg_writeback_arbiter.sv
// Writeback arbiter: mem-priority grant with an ALU anti-starvation counter.
module wb_arbiter
    import opcodes::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    alu_valid,
    input  logic    mem_valid,
    output wb_src_t grant
);

    logic [STARVE_W-1:0] starve_cnt;
    logic [STARVE_W-1:0] starve_next;
    logic                starved;

    assign starved = (starve_cnt == STARVE_LIMIT);

    always_comb begin
        grant = WB_NONE;
        if (rst) begin
            grant = WB_NONE;
        end else if (alu_valid && mem_valid) begin
            grant = starved ? WB_ALU : WB_MEM;
        end else if (mem_valid) begin
            grant = WB_MEM;
        end else if (alu_valid) begin
            grant = WB_ALU;
        end
    end

    // Counts only cycles where the ALU was waiting and lost.
    always_comb begin
        starve_next = starve_cnt;
        if (!alu_valid || grant == WB_ALU) begin
            starve_next = '0;
        end else begin
            starve_next = starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else begin
            starve_cnt <= starve_next;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Register file writeback stage with busy scoreboard and writeback counter.
// Optional WB_BYPASS_EN: register_bank shows incoming data during the transfer cycle.
module reg_writeback
    import opcodes::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          alu_valid,
    input  register_num_t alu_rd,
    input  register_t     alu_data,
    output logic          alu_ready,
    input  logic          mem_valid,
    input  register_num_t mem_rd,
    input  register_t     mem_data,
    output logic          mem_ready,
    input  logic          rsv_valid,
    input  register_num_t rsv_rd,
    output register_t     register_bank [32],
    output logic [31:0]   busy,
    output logic [31:0]   wb_count
);

    wb_src_t       grant;
    logic          wb_en;
    register_num_t wb_rd;
    register_t     wb_data;
    register_t     regs [32];
    logic [31:0]   busy_next;

    wb_arbiter u_arb (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .mem_valid (mem_valid),
        .grant     (grant)
    );

    assign alu_ready = (grant == WB_ALU);
    assign mem_ready = (grant == WB_MEM);
    assign wb_en     = (grant != WB_NONE);

    always_comb begin
        wb_rd   = '0;
        wb_data = '0;
        unique case (grant)
            WB_ALU: begin
                wb_rd   = alu_rd;
                wb_data = alu_data;
            end
            WB_MEM: begin
                wb_rd   = mem_rd;
                wb_data = mem_data;
            end
            default: begin
                wb_rd   = '0;
                wb_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != '0) begin
            regs[wb_rd] <= wb_data;
        end
    end

    // A new reservation outranks a retiring write to the same register.
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (rsv_valid) begin
            busy_next[rsv_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy     <= '0;
            wb_count <= '0;
        end else begin
            busy <= busy_next;
            if (wb_en) begin
                wb_count <= wb_count + 32'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 32; i++) begin
            register_bank[i] = regs[i];
        end
`ifdef WB_BYPASS_EN
        if (wb_en && wb_rd != '0) begin
            register_bank[wb_rd] = wb_data;
        end
`else
        register_bank[0] = regs[0];
`endif
    end

endmodule
